dmem_responder: RTL and testbench

Data-memory responder at the far end of the memory stage's load/store request interface. It accepts one request at a time over a valid/ready handshake and applies a configurable access latency. It performs RV32I byte/half/word loads and stores against an internal word array, then returns the result on a separate valid/ready response channel. It is the slave counterpart to the CPU's memory stage.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_lane_align.sv | 62 ++++++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// funct3 encodings, FSM states and the byte-enable helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Byte enables for an access of the given width at lane 0..3.
    function automatic logic [3:0] lane_be(
        input logic [2:0] f3,
        input logic [1:0] lane
    );
        logic [3:0] m;
        unique case (f3)
            F3_B, F3_BU: m = 4'b0001;
            F3_H, F3_HU: m = 4'b0011;
            default:     m = 4'b1111;
        endcase
        return m << lane;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and load extraction/extension.
// Fault detection is built only when DMEM_ERR_EN is defined.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wlane,
    output logic [31:0] rdata,
    output logic        fault
);

    logic [1:0]  lane;
    logic [31:0] rshift;

    // Halves snap to addr[1], words and illegal codes to lane 0.
    always_comb begin
        lane = 2'd0;
        unique case (1'b1)
            (funct3 == F3_B) || (funct3 == F3_BU): lane = offset;
            (funct3 == F3_H) || (funct3 == F3_HU): lane = {offset[1], 1'b0};
            default:                               lane = 2'd0;
        endcase
    end

`ifdef DMEM_ERR_EN
    // Misaligned halves/words and undefined widths are faults.
    always_comb begin
        fault = 1'b0;
        unique case (funct3)
            F3_B, F3_BU: fault = 1'b0;
            F3_H, F3_HU: fault = offset[0];
            F3_W:        fault = (offset != 2'd0);
            default:     fault = 1'b1;
        endcase
    end
`else
    assign fault = 1'b0;
`endif

    assign be     = fault ? 4'b0000 : lane_be(funct3, lane);
    assign wlane  = wdata << {lane, 3'b000};
    assign rshift = rword >> {lane, 3'b000};

    // Pick the addressed lane and sign/zero extend it.
    always_comb begin
        rdata = 32'd0;
        if (!fault) begin
            unique case (funct3)
                F3_B:    rdata = {{24{rshift[7]}}, rshift[7:0]};
                F3_BU:   rdata = {24'd0, rshift[7:0]};
                F3_H:    rdata = {{16{rshift[15]}}, rshift[15:0]};
                F3_HU:   rdata = {16'd0, rshift[15:0]};
                default: rdata = rshift;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, fixed latency, response.
// Optional fault reporting enabled by defining DMEM_ERR_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t state, state_next;
    logic [3:0]  cnt;
    logic        l_we;
    logic [2:0]  l_f3;
    logic [31:0] l_addr, l_wdata;

    logic        accept, enter_resp;
    logic        op_we;
    logic [2:0]  op_f3;
    logic [31:0] op_addr, op_wdata;
    logic [AW-1:0] idx;
    logic [31:0] rword, wlane, ldata;
    logic [3:0]  be;
    logic        fault;
    logic        unused_addr;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept = req_valid_i & req_ready_o;

    // With zero wait the access happens on the accept edge itself,
    // so the live request is used instead of the latched copy.
    assign op_we    = (state == IDLE) ? req_we_i     : l_we;
    assign op_f3    = (state == IDLE) ? req_funct3_i : l_f3;
    assign op_addr  = (state == IDLE) ? req_addr_i   : l_addr;
    assign op_wdata = (state == IDLE) ? req_wdata_i  : l_wdata;

    assign idx         = op_addr[AW+1:2];
    assign unused_addr = ^op_addr[31:AW+2];
    assign rword       = mem[idx];

    assign enter_resp = reset_ni && (state != RESP) && (state_next == RESP);

    dmem_lane_align u_align (
        .funct3 (op_f3),
        .offset (op_addr[1:0]),
        .wdata  (op_wdata),
        .rword  (rword),
        .be     (be),
        .wlane  (wlane),
        .rdata  (ldata),
        .fault  (fault)
    );

    // State and request/response registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            l_we         <= 1'b0;
            l_f3         <= 3'd0;
            l_addr       <= 32'd0;
            l_wdata      <= 32'd0;
            resp_rdata_o <= 32'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                l_we    <= req_we_i;
                l_f3    <= req_funct3_i;
                l_addr  <= req_addr_i;
                l_wdata <= req_wdata_i;
                cnt     <= CNT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                resp_rdata_o <= (op_we || fault) ? 32'd0 : ldata;
            end
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept)
                      state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT: if (cnt == 4'd0) state_next = RESP;
            RESP: if (resp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        req_ready_o  = (state == IDLE);
        resp_valid_o = (state == RESP);
    end

    // Array write of the enabled lanes on entry to RESP; not reset.
    always_ff @(posedge clk_i) begin
        if (enter_resp && op_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

`ifdef DMEM_ERR_EN
    logic err_q;

    // Fault flag captured alongside the response data.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            err_q <= 1'b0;
        end else if (enter_resp) begin
            err_q <= fault;
        end
    end

    assign resp_err_o = err_q;
`else
    assign resp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: two instances
// (WAIT=3/1024 words and WAIT=0/16 words) against a byte-array model.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]       req_valid, req_we, resp_ready;
    logic [1:0][2:0]  req_f3;
    logic [1:0][31:0] req_addr, req_wdata;
    wire  [1:0]       req_ready, resp_valid, resp_err;
    wire  [1:0][31:0] resp_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mm [2][4096];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_big (
        .clk_i        (clk),
        .reset_ni     (rst_n),
        .req_valid_i  (req_valid[0]),
        .req_ready_o  (req_ready[0]),
        .req_we_i     (req_we[0]),
        .req_funct3_i (req_f3[0]),
        .req_addr_i   (req_addr[0]),
        .req_wdata_i  (req_wdata[0]),
        .resp_valid_o (resp_valid[0]),
        .resp_ready_i (resp_ready[0]),
        .resp_rdata_o (resp_rdata[0]),
        .resp_err_o   (resp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_small (
        .clk_i        (clk),
        .reset_ni     (rst_n),
        .req_valid_i  (req_valid[1]),
        .req_ready_o  (req_ready[1]),
        .req_we_i     (req_we[1]),
        .req_funct3_i (req_f3[1]),
        .req_addr_i   (req_addr[1]),
        .req_wdata_i  (req_wdata[1]),
        .resp_valid_o (resp_valid[1]),
        .resp_ready_i (resp_ready[1]),
        .resp_rdata_o (resp_rdata[1]),
        .resp_err_o   (resp_err[1])
    );

    function automatic int wt(input int w);
        return (w != 0) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory, RV32I rules.
    task automatic model(input int w, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
        int nb;
        int ba;
        bit ill;
        bit sx;
        ill = 0;
        sx  = 0;
        nb  = 4;
        case (f3)
            3'b000: begin nb = 1; sx = 1; end
            3'b100: nb = 1;
            3'b001: begin nb = 2; sx = 1; end
            3'b101: nb = 2;
            3'b010: nb = 4;
            default: begin nb = 4; ill = 1; end
        endcase
        ba = int'(a % ((w != 0) ? 32'd64 : 32'd4096));
        rd = 32'd0;
        er = 1'b0;
`ifdef DMEM_ERR_EN
        if (ill || (ba % nb) != 0) begin
            er = 1'b1;
            return;
        end
`else
        ba = ba - (ba % nb);
`endif
        if (we) begin
            for (int i = 0; i < nb; i++) mm[w][ba+i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < nb; i++) rd[8*i +: 8] = mm[w][ba+i];
            if (sx && rd[8*nb-1])
                for (int i = nb; i < 4; i++) rd[8*i +: 8] = 8'hFF;
        end
    endtask

    task automatic txn(input int w, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int hold, output logic [31:0] rd);
        logic [31:0] erd;
        logic        eerr;
        int          n;
        n = 0;
        @(negedge clk);
        while (!req_ready[w] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", 32'(req_ready[w]), 32'd1);
        req_valid[w] = 1'b1;
        req_we[w]    = we;
        req_f3[w]    = f3;
        req_addr[w]  = a;
        req_wdata[w] = wd;
        @(posedge clk);
        #1;
        req_we[w]    = ~we;
        req_f3[w]    = 3'($urandom);
        req_addr[w]  = $urandom;
        req_wdata[w] = $urandom;
        model(w, we, f3, a, wd, erd, eerr);
        n = 0;
        @(negedge clk);
        while (!resp_valid[w] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(wt(w)));
        check("rdata", resp_rdata[w], erd);
        check("err", 32'(resp_err[w]), 32'(eerr));
        rd = resp_rdata[w];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(resp_valid[w]), 32'd1);
            check("hold_rdata", resp_rdata[w], erd);
            check("hold_ready", 32'(req_ready[w]), 32'd0);
        end
        req_valid[w]  = 1'b0;
        resp_ready[w] = 1'b1;
        @(negedge clk);
        check("done_valid", 32'(resp_valid[w]), 32'd0);
        check("done_ready", 32'(req_ready[w]), 32'd1);
        resp_ready[w] = 1'b0;
    endtask

    logic [31:0] rd;
    logic [31:0] ra;

    initial begin
        req_valid  = '0;
        req_we     = '0;
        resp_ready = '0;
        req_f3     = '0;
        req_addr   = '0;
        req_wdata  = '0;

        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            check("rst_ready", 32'(req_ready[w]), 32'd1);
            check("rst_valid", 32'(resp_valid[w]), 32'd0);
            check("rst_rdata", resp_rdata[w], 32'd0);
            check("rst_err", 32'(resp_err[w]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(req_ready[0]), 32'd1);
        check("rel_valid", 32'(resp_valid[0]), 32'd0);

        // Byte lanes and extension on the big instance
        txn(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd);
        check("sw_rdata0", rd, 32'd0);
        txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, rd);
        check("lw_dead", rd, 32'hDEADBEEF);
        txn(0, 1'b1, 3'b000, 32'h13, 32'h80, 0, rd);
        txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 5, rd);
        check("lw_sb", rd, 32'h80ADBEEF);
        txn(0, 1'b0, 3'b000, 32'h13, 32'h0, 0, rd);
        check("lb", rd, 32'hFFFFFF80);
        txn(0, 1'b0, 3'b100, 32'h13, 32'h0, 0, rd);
        check("lbu", rd, 32'h00000080);
        txn(0, 1'b0, 3'b001, 32'h12, 32'h0, 2, rd);
        check("lh", rd, 32'hFFFF80AD);
        txn(0, 1'b0, 3'b101, 32'h12, 32'h0, 0, rd);
        check("lhu", rd, 32'h000080AD);

        // Zero wait and address aliasing on the small instance
        txn(1, 1'b1, 3'b010, 32'h1000, 32'h12345678, 0, rd);
        txn(1, 1'b0, 3'b010, 32'h0, 32'h0, 3, rd);
        check("alias", rd, 32'h12345678);

        // Misaligned half and illegal funct3
        txn(0, 1'b1, 3'b010, 32'h20, 32'h55667788, 0, rd);
        txn(0, 1'b1, 3'b001, 32'h21, 32'h0000FFFF, 0, rd);
        txn(0, 1'b0, 3'b010, 32'h20, 32'h0, 0, rd);
        txn(0, 1'b0, 3'b011, 32'h20, 32'h0, 0, rd);
        txn(1, 1'b1, 3'b111, 32'h22, 32'hCAFEF00D, 0, rd);

        // Reset during WAIT drops the pending store
        txn(0, 1'b1, 3'b010, 32'h40, 32'h11223344, 0, rd);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_f3[0]    = 3'b010;
        req_addr[0]  = 32'h40;
        req_wdata[0] = 32'hAAAAAAAA;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(resp_valid[0]), 32'd0);
        check("mid_rst_ready", 32'(req_ready[0]), 32'd1);
        repeat (2) @(negedge clk);
        check("mid_rst_hold", 32'(resp_valid[0]), 32'd0);
        rst_n = 1'b1;
        txn(0, 1'b0, 3'b010, 32'h40, 32'h0, 0, rd);
        check("no_write", rd, 32'h11223344);

        // Fill the random windows, then random traffic
        for (int i = 0; i < 16; i++) begin
            txn(0, 1'b1, 3'b010, 32'h100 + 32'(4*i), $urandom, 0, rd);
            txn(1, 1'b1, 3'b010, 32'(4*i), $urandom, 0, rd);
        end
        for (int k = 0; k < 200; k++) begin
            int w;
            w  = int'($urandom_range(0, 1));
            ra = $urandom;
            if (w == 0) ra = (ra & 32'hFFFF_F03F) | 32'h100;
            txn(w, 1'($urandom), 3'($urandom), ra, $urandom,
                int'($urandom_range(0, 2)), rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
